// File: rtl/pwm_ctrl_pkg.sv
// Shared types, default widths and step arithmetic
// for the PWM soft-start ramp controller.
package pwm_ctrl_pkg;

  localparam int DEF_DUTY_W   = 8;
  localparam int DEF_PWM_BITS = 8;
  localparam int DEF_INT_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    STOP
  } state_t;

  // Move duty toward tgt by step, landing exactly on tgt.
  function automatic logic [31:0] sat_step(
    input logic [31:0] duty,
    input logic [31:0] step,
    input logic [31:0] tgt
  );
    if (tgt > duty) begin
      if (tgt - duty <= step) return tgt;
      return duty + step;
    end
    if (duty - tgt <= step) return tgt;
    return duty - step;
  endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter; ticks in
// the last clock of every 2^PWM_BITS period.
module pwm_period_timer
  import pwm_ctrl_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS
) (
  input  logic clk,
  input  logic rst_n,
  output logic period_tick
);

  logic [PWM_BITS-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count + PWM_BITS'(1);
  end

  assign period_tick = &count;

endmodule

// File: rtl/pwm_ramp_controller.sv
// Soft-start duty sequencer: ramps duty_cycle toward
// an accepted target on PWM period boundaries.
module pwm_ramp_controller
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W   = DEF_DUTY_W,
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int INT_W    = DEF_INT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [DUTY_W-1:0] tgt_duty,
  input  logic [DUTY_W-1:0] tgt_step,
  input  logic [INT_W-1:0]  tgt_interval,
  input  logic              estop,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              period_tick,
  output logic              busy,
  output logic              done
);

  state_t state, state_d;

  logic [DUTY_W-1:0] duty_d;
  logic [DUTY_W-1:0] tgt, tgt_d;
  logic [DUTY_W-1:0] step, step_d;
  logic [INT_W-1:0]  intv, intv_d;
  logic [INT_W-1:0]  icnt, icnt_d;
  logic [INT_W-1:0]  icnt_inc;
  logic [DUTY_W-1:0] stepped;
  logic              done_d;
  logic              busy_d;
  logic              accept;

  pwm_period_timer #(
    .PWM_BITS(PWM_BITS)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .period_tick(period_tick)
  );

  assign tgt_ready = (state != STOP) && !estop;
  assign accept    = tgt_valid && tgt_ready;
  assign icnt_inc  = icnt + INT_W'(1);
  assign stepped   = DUTY_W'(sat_step(32'(duty_cycle),
                                      32'(step),
                                      32'(tgt)));

  // Priority: estop, then accept, then a due step.
  always_comb begin
    state_d = state;
    duty_d  = duty_cycle;
    tgt_d   = tgt;
    step_d  = step;
    intv_d  = intv;
    icnt_d  = icnt;
    done_d  = 1'b0;
    if (estop) begin
      state_d = STOP;
      duty_d  = '0;
      tgt_d   = '0;
      icnt_d  = '0;
    end else if (accept) begin
      tgt_d  = tgt_duty;
      step_d = (tgt_step == '0) ? DUTY_W'(1)
                                : tgt_step;
      intv_d = (tgt_interval == '0) ? INT_W'(1)
                                    : tgt_interval;
      icnt_d = '0;
      if (tgt_duty == duty_cycle) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        state_d = RAMP;
      end
    end else if (state == STOP) begin
      state_d = IDLE;
    end else if (state == RAMP && period_tick) begin
      if (icnt_inc == intv) begin
        icnt_d = '0;
        duty_d = stepped;
        if (stepped == tgt) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end else begin
        icnt_d = icnt_inc;
      end
    end
  end

  // busy lingers through the done cycle of a ramp.
  assign busy_d = (state_d == RAMP) ||
                  (state == RAMP && done_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      duty_cycle <= '0;
      tgt        <= '0;
      step       <= '0;
      intv       <= '0;
      icnt       <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      duty_cycle <= duty_d;
      tgt        <= tgt_d;
      step       <= step_d;
      intv       <= intv_d;
      icnt       <= icnt_d;
      done       <= done_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: doc/pwm_ramp_controller.md
# pwm_ramp_controller

Soft-start sequencer that drives the 8-bit `DUTY_CYCLE` input of the PWM generator. It accepts a target duty over a valid/ready handshake and ramps its registered duty output toward that target. The ramp moves by a programmable step every programmable number of PWM periods, and updates only on PWM period boundaries. It sits between motor-control logic and the PWM generator, and also provides an emergency-stop path that forces the duty to zero immediately.

## Interface
- `DUTY_W`, default 8: width of duty, target and step.
- `PWM_BITS`, default 8: PWM period is 2^PWM_BITS clocks; must match the generator's counter width.
- `INT_W`, default 8: width of the interval field.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tgt_valid`  in  1  a new target request is present.
- `tgt_ready`  out  1  the block can accept a target.
- `tgt_duty`  in  DUTY_W  requested final duty.
- `tgt_step`  in  DUTY_W  duty change per step; 0 is treated as 1.
- `tgt_interval`  in  INT_W  PWM periods per step; 0 is treated as 1.
- `estop`  in  1  emergency stop, level-sensitive.
- `duty_cycle`  out  DUTY_W  registered; connects to the generator's `DUTY_CYCLE`.
- `period_tick`  out  1  high during the last clock of each PWM period.
- `busy`  out  1  high while in RAMP.
- `done`  out  1  one-cycle pulse when the ramp reaches the target.

## Operation
- States:
  - IDLE: `duty_cycle` is held.
  - RAMP: stepping toward the latched target.
  - STOP: emergency stop.
- `tgt_ready` = (state != STOP) && !estop; it is combinational. Accept occurs when `tgt_valid && tgt_ready`.
- On accept:
  - latch target, step and interval, each zero-corrected as stated in the Interface;
  - clear the interval counter.
  - If target == `duty_cycle`: pulse `done` on the next cycle and go to (or stay in) IDLE.
  - Otherwise go to RAMP.
- Retarget in RAMP is allowed. The new values replace the old ones, `duty_cycle` holds its current value, and the interval counter restarts.
- In RAMP, each `period_tick` increments the interval counter. When the counter reaches the interval value:
  - clear the counter;
  - move `duty_cycle` toward the target by step.
- Step arithmetic:
  - Compute in DUTY_W+1 bits and saturate at the target, with no overshoot and no wrap.
  - Upward: min(duty+step, target). Downward: max(duty−step, target).
- When a step lands on the target: pulse `done` in the same cycle as the update, then go to IDLE.
- estop high, from any state:
  - on the next clock edge, `duty_cycle` becomes 0; this is not boundary-aligned;
  - go to STOP;
  - discard the latched target and clear the interval counter;
  - `done` is never pulsed.
- STOP → IDLE on the first clock where estop is low. `duty_cycle` stays 0.
- The period counter runs freely in all states, including STOP.

## Timing
- Reset values:
  - `duty_cycle`=0, `busy`=0, `done`=0, `period_tick`=0;
  - `tgt_ready`=1 once reset releases (if estop is low);
  - state IDLE, all counters 0.
- Async reset mid-ramp: all outputs return to reset values immediately.
- `period_tick` is high when the period counter == 2^PWM_BITS−1. A duty update lands on the edge that ends that cycle, so the new duty is valid from the first clock of the next period.
- First step occurs on the `tgt_interval`-th `period_tick` strictly after the accept cycle.
- Accept in the same cycle as `period_tick`: the accept wins, and that tick does not count toward the interval.
- estop in the same cycle as a due step: the estop wins, and duty goes to 0.
- estop in the same cycle as `tgt_valid`: no accept, because ready is 0.
- `busy` is registered. It rises the cycle after accept and falls in the cycle after `done`.

## Structure
- Package `pwm_ctrl_pkg` holds:
  - the state enum (IDLE, RAMP, STOP);
  - default width constants (DUTY_W, PWM_BITS, INT_W);
  - the saturating step function.
- Sub-module `pwm_period_timer` contains the free-running PWM_BITS counter and the `period_tick` output. It is reusable by the generator side.
- The top level contains the FSM, target/step/interval registers, the interval counter and the duty register.

## Test plan
Bench uses PWM_BITS=3 (period 8 clocks) with an instantiated PWM generator.
- Reset: hold `rst_n`=0, then release. Required: `duty_cycle`=0, `tgt_ready`=1, `busy`=0, `done`=0, and the first `period_tick` 8 clocks after release.
- Up ramp, starting from duty 0: target 200, step 50, interval 1. Required: `duty_cycle` = 50, 100, 150, 200 on successive period boundaries, a single `done` with the 200 update, then IDLE.
- Down ramp with saturation, starting from duty 200: target 30, step 100, interval 2. Required: 100 after 2 ticks, 30 after 4 ticks (never 0 and never wrapped), then `done`.
- Zero correction, starting from duty 0: target 3, step 0, interval 0. Required: duty 1, 2, 3 on consecutive ticks.
- Estop mid-ramp: assert estop at duty 100 during a 0→200 ramp. Required:
  - `duty_cycle`=0 on the next edge;
  - `tgt_ready`=0 and no `done`;
  - after estop release, state is IDLE with duty 0.
- Retarget and collisions:
  - Retarget to 60 while at 100 on a 0→200 ramp: required ramp down to 60.
  - Accept coincident with `period_tick`: that tick is not counted.
  - Accept of target == current duty: required `done` on the next cycle.
  - `rst_n` low mid-ramp: required immediate reset values.
